// File: rtl/writeback_queue.sv
// writeback_queue: in-order result buffer that feeds the register file write port.
// Define WB_BYPASS_EN to forward pending results to the two operand read ports.
module writeback_queue #(
  parameter int DataWidth = 16,
  parameter int NumRegs   = 16,
  parameter int Depth     = 4,
  localparam int AddrWidth = $clog2(NumRegs),
  localparam int CntWidth  = $clog2(Depth) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AddrWidth-1:0] in_addr,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 wb_stall,
  output logic                 reg_w_en,
  output logic [AddrWidth-1:0] addr_in,
  output logic [DataWidth-1:0] reg_in,
  input  logic [AddrWidth-1:0] rd_addr1,
  input  logic [AddrWidth-1:0] rd_addr2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [DataWidth-1:0] fwd_data1,
  output logic [DataWidth-1:0] fwd_data2,
  output logic [CntWidth-1:0]  count
);

  localparam int PtrWidth = $clog2(Depth);
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(Depth);

  logic [AddrWidth-1:0] addr_mem_q [Depth];
  logic [DataWidth-1:0] data_mem_q [Depth];

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                push;
  logic                pop;

  // A pop in the same cycle never frees a slot for a push while full.
  always_comb begin
    in_ready = (count_q != FullCount);
    push     = in_valid && in_ready && rst_n;
    // Holding off the write while rst_n is low keeps discarded entries out of the register file.
    pop      = (count_q != '0) && !wb_stall && rst_n;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    reg_w_en = pop;
    count    = count_q;
    addr_in  = '0;
    reg_in   = '0;
    if (count_q != '0) begin
      addr_in = addr_mem_q[rd_ptr_q];
      reg_in  = data_mem_q[rd_ptr_q];
    end
  end

`ifdef WB_BYPASS_EN
  logic [Depth-1:0]    occupied;
  logic [Depth-1:0]    match1;
  logic [Depth-1:0]    match2;
  logic [PtrWidth-1:0] scan_idx;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    logic [PtrWidth-1:0] age;
    assign age          = PtrWidth'(gi) - rd_ptr_q;
    assign occupied[gi] = (CntWidth'(age) < count_q);
    assign match1[gi]   = occupied[gi] && (addr_mem_q[gi] == rd_addr1);
    assign match2[gi]   = occupied[gi] && (addr_mem_q[gi] == rd_addr2);
  end

  // Walk oldest to youngest so the last hit seen is the youngest pending value.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    scan_idx  = rd_ptr_q;
    for (int k = 0; k < Depth; k++) begin
      scan_idx = rd_ptr_q + PtrWidth'(k);
      if (match1[scan_idx]) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_mem_q[scan_idx];
      end
      if (match2[scan_idx]) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_mem_q[scan_idx];
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule
